// File: rtl/seg7_pattern_decoder.sv
// Receive-side 7-segment pattern decoder: debounces seg_in, then maps each newly settled pattern back to its symbol code.
// Optional saturating error counter on port err_count is present only when SEG7_DEC_ERRCNT_EN is defined.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CODE_W        = 6,
    parameter int ERRCNT_W      = 8
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [7:0]        seg_in,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              seg_err,
    output logic              locked
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] err_count
`endif
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic [7:0]        cand_q, cand_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [7:0]        acc_q, acc_d;
    logic              acc_valid_q, acc_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic              seg_err_q, seg_err_d;
    logic              locked_q, locked_d;

    logic              same_sample;
    logic              accept;
    logic              lookup_hit;
    logic [CODE_W-1:0] lookup_code;

    // Pattern-to-code table; duplicated patterns would resolve to the lowest code.
    // Any pattern with dp (bit7) set falls through to the miss branch.
    function automatic logic [CODE_W:0] seg_lookup(input logic [7:0] p);
        logic hit;
        int   c;
        hit = 1'b1;
        c   = 0;
        case (p)
            8'h3F: c = 0;
            8'h06: c = 1;
            8'h5B: c = 2;
            8'h4F: c = 3;
            8'h66: c = 4;
            8'h6D: c = 5;
            8'h7D: c = 6;
            8'h07: c = 7;
            8'h7F: c = 8;
            8'h6F: c = 9;
            8'h77: c = 10;
            8'h7C: c = 11;
            8'h39: c = 12;
            8'h5E: c = 13;
            8'h79: c = 14;
            8'h71: c = 15;
            8'h58: c = 19;
            8'h76: c = 24;
            8'h74: c = 25;
            8'h04: c = 26;
            8'h1E: c = 28;
            8'h38: c = 29;
            8'h54: c = 30;
            8'h5C: c = 32;
            8'h73: c = 33;
            8'h67: c = 34;
            8'h50: c = 35;
            8'h78: c = 37;
            8'h3E: c = 38;
            8'h1C: c = 39;
            8'h6E: c = 40;
            8'h63: c = 41;
            default: begin
                hit = 1'b0;
                c   = 0;
            end
        endcase
        return {hit, CODE_W'(c)};
    endfunction

    always_comb begin
        cand_d       = cand_q;
        run_d        = run_q;
        acc_d        = acc_q;
        acc_valid_d  = acc_valid_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        seg_err_d    = 1'b0;
        locked_d     = locked_q;

        // A run of zero means nothing sampled yet since reset.
        same_sample = (run_q != '0) && (seg_in == cand_q);
        if (same_sample) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_ONE;
            end
        end else begin
            cand_d   = seg_in;
            run_d    = RUN_ONE;
            locked_d = 1'b0;
        end

        {lookup_hit, lookup_code} = seg_lookup(cand_d);

        // While saturated, acceptance repeats every edge but only re-locks.
        accept = (run_d == RUN_MAX);
        if (accept) begin
            locked_d = 1'b1;
            if (!(acc_valid_q && (cand_d == acc_q))) begin
                acc_d       = cand_d;
                acc_valid_d = 1'b1;
                if (lookup_hit) begin
                    code_d       = lookup_code;
                    code_valid_d = 1'b1;
                end else begin
                    seg_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            cand_q       <= '0;
            run_q        <= '0;
            acc_q        <= '0;
            acc_valid_q  <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            seg_err_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            cand_q       <= cand_d;
            run_q        <= run_d;
            acc_q        <= acc_d;
            acc_valid_q  <= acc_valid_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            seg_err_q    <= seg_err_d;
            locked_q     <= locked_d;
        end
    end

    assign code       = code_q;
    assign code_valid = code_valid_q;
    assign seg_err    = seg_err_q;
    assign locked     = locked_q;

`ifdef SEG7_DEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (seg_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERRCNT_W'(1);
        end
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: debounce latency, glitch rejection,
// error patterns, code sequence and mid-run reset.
module tb_seg7_pattern_decoder;

  logic       clk_2;
  logic       reset;
  logic [7:0] seg_in;
  logic [5:0] code;
  logic       code_valid;
  logic       seg_err;
  logic       locked;
`ifdef SEG7_DEC_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_checks;
  int n_errors;
  int cv_cnt;
  int se_cnt;
  int both_cnt;
  logic [5:0] exp_q[$];

  seg7_pattern_decoder #(
    .STABLE_CYCLES(4),
    .CODE_W(6),
    .ERRCNT_W(8)
  ) dut (
    .clk_2(clk_2),
    .reset(reset),
    .seg_in(seg_in),
    .code(code),
    .code_valid(code_valid),
    .seg_err(seg_err),
    .locked(locked)
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  // clock / reset
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: advance n edges, sampling 1ns after each edge and tallying strobes
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_2);
      #1;
      if (code_valid) cv_cnt++;
      if (seg_err) se_cnt++;
      if (code_valid && seg_err) both_cnt++;
    end
  endtask

  task automatic clear_counts();
    cv_cnt = 0;
    se_cnt = 0;
    both_cnt = 0;
  endtask

  initial begin
    logic [7:0] pats[4];
    logic [5:0] exp_code;
    n_checks = 0;
    n_errors = 0;
    clear_counts();
    pats[0] = 8'h3F; pats[1] = 8'h06; pats[2] = 8'h77; pats[3] = 8'h63;

    reset = 1'b1;
    seg_in = 8'h00;
    step(2);
    check("rst_code", 32'(code), 32'd0);
    check("rst_cv", 32'(code_valid), 32'd0);
    check("rst_err", 32'(seg_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("rst_errcnt", 32'(err_count), 32'd0);
`endif

    // 1: 5B held 4 edges
    reset = 1'b0;
    seg_in = 8'h5B;
    clear_counts();
    step(3);
    check("t1_no_early_strobe", 32'(cv_cnt), 32'd0);
    check("t1_unlocked_early", 32'(locked), 32'd0);
    step(1);
    check("t1_cv", 32'(code_valid), 32'd1);
    check("t1_code", 32'(code), 32'd2);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_err", 32'(seg_err), 32'd0);

    // 2: hold 10 more edges
    clear_counts();
    step(10);
    check("t2_no_strobe", 32'(cv_cnt + se_cnt), 32'd0);
    check("t2_code", 32'(code), 32'd2);
    check("t2_locked", 32'(locked), 32'd1);

    // 3: 2-edge glitch to 6F then back
    clear_counts();
    seg_in = 8'h6F;
    step(1);
    check("t3_glitch_unlock", 32'(locked), 32'd0);
    step(1);
    seg_in = 8'h5B;
    step(3);
    check("t3_still_unlocked", 32'(locked), 32'd0);
    step(1);
    check("t3_relocked", 32'(locked), 32'd1);
    check("t3_no_strobe", 32'(cv_cnt + se_cnt), 32'd0);
    check("t3_code", 32'(code), 32'd2);

    // 4: 80 is an error pattern
    clear_counts();
    seg_in = 8'h80;
    step(4);
    check("t4_err_pulse", 32'(seg_err), 32'd1);
    check("t4_cv", 32'(code_valid), 32'd0);
    check("t4_code", 32'(code), 32'd2);
`ifdef SEG7_DEC_ERRCNT_EN
    check("t4_errcnt", 32'(err_count), 32'd1);
`endif
    step(1);
    check("t4_err_one_cycle", 32'(seg_err), 32'd0);
    check("t4_err_total", 32'(se_cnt), 32'd1);
    check("t4_cv_total", 32'(cv_cnt), 32'd0);

    // 5: code sequence via expected queue
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd1);
    exp_q.push_back(6'd10);
    exp_q.push_back(6'd41);
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      seg_in = pats[k];
      step(3);
      check("t5_no_early", 32'(code_valid), 32'd0);
      step(1);
      exp_code = exp_q.pop_front();
      check("t5_cv", 32'(code_valid), 32'd1);
      check("t5_code", 32'(code), 32'(exp_code));
    end
    check("t5_pulses", 32'(cv_cnt), 32'd4);
    check("t5_no_err", 32'(se_cnt), 32'd0);
    check("t5_no_overlap", 32'(both_cnt), 32'd0);

    // 6: reset in the middle of a 7D run
    seg_in = 8'h7D;
    step(2);
    reset = 1'b1;
    #1;
    check("t6_async_code", 32'(code), 32'd0);
    check("t6_async_locked", 32'(locked), 32'd0);
    check("t6_async_cv", 32'(code_valid), 32'd0);
`ifdef SEG7_DEC_ERRCNT_EN
    check("t6_async_errcnt", 32'(err_count), 32'd0);
`endif
    step(1);
    reset = 1'b0;
    clear_counts();
    step(3);
    check("t6_no_early", 32'(cv_cnt), 32'd0);
    step(1);
    check("t6_cv", 32'(code_valid), 32'd1);
    check("t6_code", 32'(code), 32'd6);
    step(3);
    check("t6_one_pulse", 32'(cv_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
